// File: rtl/sp1_pkg.sv
// Shared definitions for the SP1 arithmetic/compare slice.
// Default datapath width and the word type used by the surrounding datapath.
package sp1_pkg;

  localparam int SP1_DW = 16;

  typedef logic [SP1_DW-1:0] sp1_word_t;

endpackage : sp1_pkg

// File: rtl/sp1_cmp_core.sv
// Combinational unsigned comparator: eq and gt from a subtract-borrow.
// Independent of the adder so the compare flags never depend on the sum path.
module sp1_cmp_core #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          eq,
  output logic          gt
);

  logic [DW:0] diff;
  logic        borrow;

  // A borrow out of the top bit means a < b; no borrow and not equal means a > b.
  assign diff   = {1'b0, a} - {1'b0, b};
  assign borrow = diff[DW];
  assign eq     = (a == b);
  assign gt     = ~borrow & ~eq;

endmodule : sp1_cmp_core

// File: rtl/sp1_arith_cmp_unit.sv
// Registered add/compare slice: sum with carry-out, equality and unsigned
// greater-than, all produced one cycle after the operands are accepted.
module sp1_arith_cmp_unit
  import sp1_pkg::*;
#(
  parameter int DW = SP1_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_valid,
  output logic [DW-1:0] y,
  output logic          c,
  output logic          eq,
  output logic          gt
);

  logic [DW:0]   sum_next;
  logic          eq_next;
  logic          gt_next;

  logic          valid_reg;
  logic [DW-1:0] y_reg;
  logic          c_reg;
  logic          eq_reg;
  logic          gt_reg;

  assign sum_next = {1'b0, a} + {1'b0, b};

  sp1_cmp_core #(
    .DW (DW)
  ) u_cmp (
    .a  (a),
    .b  (b),
    .eq (eq_next),
    .gt (gt_next)
  );

  // Result registers load only on valid cycles, so idle operands never leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      y_reg     <= '0;
      c_reg     <= 1'b0;
      eq_reg    <= 1'b0;
      gt_reg    <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        y_reg  <= sum_next[DW-1:0];
        c_reg  <= sum_next[DW];
        eq_reg <= eq_next;
        gt_reg <= gt_next;
      end
    end
  end

  assign out_valid = valid_reg;
  assign y         = y_reg;
  assign c         = c_reg;
  assign eq        = eq_reg;
  assign gt        = gt_reg;

endmodule : sp1_arith_cmp_unit

// File: tb/tb_sp1_arith_cmp_unit.sv
// Scoreboard bench for sp1_arith_cmp_unit: directed corner cases plus random traffic.
module tb_sp1_arith_cmp_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] y;
  logic        c;
  logic        eq;
  logic        gt;

  int total;
  int bad;

  // One expected entry per clock edge: {out_valid, y, c, eq, gt}
  logic [19:0] exp_q[$];

  // Reference state: what the outputs should show after the next edge
  logic        hv;
  logic [15:0] hy;
  logic        hc;
  logic        heq;
  logic        hgt;

  sp1_arith_cmp_unit #(
    .DW (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .y         (y),
    .c         (c),
    .eq        (eq),
    .gt        (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic v, input logic [15:0] aa, input logic [15:0] bb);
    int s;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = aa;
    b        = bb;
    if (r) begin
      hv = 1'b0; hy = 16'h0; hc = 1'b0; heq = 1'b0; hgt = 1'b0;
    end else begin
      hv = v;
      if (v) begin
        s   = int'(aa) + int'(bb);
        hy  = 16'(s % 65536);
        hc  = (s >= 65536);
        heq = (int'(aa) == int'(bb));
        hgt = (int'(aa) > int'(bb));
      end
    end
    exp_q.push_back({hv, hy, hc, heq, hgt});
  endtask

  // Monitor: after every edge, pop the expectation for that edge and compare
  initial begin
    logic [19:0] e;
    logic [19:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {out_valid, y, c, eq, gt};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got v=%b y=%h c=%b eq=%b gt=%b need v=%b y=%h c=%b eq=%b gt=%b",
                   $time, act[19], act[18:3], act[2], act[1], act[0],
                   e[19], e[18:3], e[2], e[1], e[0]);
        end else begin
          $display("ok t=%0t v=%b y=%h c=%b eq=%b gt=%b", $time, act[19], act[18:3], act[2], act[1], act[0]);
        end
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rv;
    logic        rr;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 16'h0;
    b        = 16'h0;
    hv = 1'b0; hy = 16'h0; hc = 1'b0; heq = 1'b0; hgt = 1'b0;

    // Reset held, then released with nothing valid
    repeat (5) drive(1'b1, 1'b0, 16'h0, 16'h0);
    repeat (3) drive(1'b0, 1'b0, 16'h0, 16'h0);

    // Directed corners
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0001);
    drive(1'b0, 1'b0, 16'hxxxx, 16'hxxxx);
    drive(1'b0, 1'b1, 16'h1234, 16'h1234);
    drive(1'b0, 1'b1, 16'h0000, 16'h8000);
    drive(1'b0, 1'b1, 16'h8000, 16'h7FFF);
    drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    drive(1'b0, 1'b0, 16'hxxxx, 16'hxxxx);

    // Three back-to-back, then idle: y must hold the last sum
    drive(1'b0, 1'b1, 16'h0010, 16'h0020);
    drive(1'b0, 1'b1, 16'hA000, 16'h7000);
    drive(1'b0, 1'b1, 16'h0005, 16'h0009);
    repeat (2) drive(1'b0, 1'b0, 16'hxxxx, 16'hxxxx);

    // Reset in the middle of a valid stream, then resume
    drive(1'b0, 1'b1, 16'h1111, 16'h2222);
    drive(1'b1, 1'b1, 16'h3333, 16'h0001);
    drive(1'b0, 1'b1, 16'h4000, 16'h3FFF);
    drive(1'b0, 1'b1, 16'hC000, 16'h4000);

    // Random traffic with boundary-biased operands and occasional reset
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: rb = 16'hFFFF - ra;
        2: rb = ra + 16'h0001;
        3: rb = ra - 16'h0001;
        default: rb = 16'($urandom);
      endcase
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 39) == 0);
      if (rv) drive(rr, 1'b1, ra, rb);
      else    drive(rr, 1'b0, 16'hxxxx, 16'hxxxx);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d need 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sp1_arith_cmp_unit
